// File: rtl/core_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : core_ctrl_pkg                                              |
// | Description : Shared types and defaults for the core run controller.     |
// |               run_state_t is the host run handshake state.               |
// |               cnt_width() sizes a counter that must reach a given value. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package core_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    RUN    = 2'd2,
    REPORT = 2'd3
  } run_state_t;

  localparam int unsigned DEF_RESET_CYCLES = 2;
  localparam int unsigned DEF_TIMEOUT      = 1024;
  localparam int unsigned DEF_CNT_W        = 16;

  // Bits needed to hold every value 0..max_val (never less than one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage : core_ctrl_pkg
`default_nettype wire

// File: rtl/run_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : run_counter                                                |
// | Description : Clear/enable up-counter that saturates at TERMINAL.        |
// |               o_tc flags that the count sits one below TERMINAL, so the  |
// |               enabled cycle in progress is the one that reaches it.      |
// | Ports       : clk      in  clock, rising edge                            |
// |               rst_n    in  asynchronous active-low reset                 |
// |               i_clr    in  synchronous clear to zero (beats i_en)        |
// |               i_en     in  count up by one                               |
// |               o_count  out current count                                 |
// |               o_tc     out count == TERMINAL-1                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module run_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned TERMINAL = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc
);

  localparam logic [WIDTH-1:0] LAST  = WIDTH'(TERMINAL);
  localparam logic [WIDTH-1:0] TC_AT = WIDTH'(TERMINAL - 1);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // Saturating at TERMINAL keeps the count from ever wrapping, even if the
  // enable is left on after the terminal value was reached.
  always_comb begin
    count_d = count_q;
    if (i_clr) begin
      count_d = '0;
    end else if (i_en && (count_q != LAST)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;
  assign o_tc    = (count_q == TC_AT);

endmodule : run_counter
`default_nettype wire

// File: rtl/core_run_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : core_run_ctrl                                              |
// | Description : Responder for the host Req/Ack run handshake. Holds the    |
// |               core in reset for RESET_CYCLES, releases it, counts run    |
// |               cycles until CoreDone or TIMEOUT, then raises Ack with the |
// |               cycle count and a timeout flag until Req is dropped.       |
// | Ports       : Clk        in  clock, rising edge                          |
// |               Reset      in  asynchronous active-low reset               |
// |               Req        in  host run request (4-phase level)            |
// |               Ack        out run complete, results valid                 |
// |               CoreReset  out active-high reset to the core               |
// |               CoreDone   in  core completion flag                        |
// |               Busy       out high while holding or running the core      |
// |               CycleCount out run cycles up to and including Done cycle   |
// |               TimedOut   out run ended by timeout rather than Done       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module core_run_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int unsigned RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Req,
  output logic             Ack,
  output logic             CoreReset,
  input  logic             CoreDone,
  output logic             Busy,
  output logic [CNT_W-1:0] CycleCount,
  output logic             TimedOut
);

  localparam int unsigned HOLD_W = cnt_width(RESET_CYCLES);

  run_state_t state_d;
  run_state_t state_q;

  logic core_reset_d;
  logic core_reset_q;
  logic ack_d;
  logic ack_q;
  logic busy_d;
  logic busy_q;
  logic timed_out_d;
  logic timed_out_q;

  logic              hold_clr;
  logic              hold_en;
  logic              hold_tc;
  logic [HOLD_W-1:0] hold_cnt;

  logic              cyc_clr;
  logic              cyc_en;
  logic              cyc_tc;
  logic [CNT_W-1:0]  cyc_cnt;

  // Only the terminal flag of the hold counter steers the FSM.
  logic unused_hold_cnt;
  assign unused_hold_cnt = ^hold_cnt;

  run_counter #(
    .WIDTH    (HOLD_W),
    .TERMINAL (RESET_CYCLES)
  ) u_hold_cnt (
    .clk     (Clk),
    .rst_n   (Reset),
    .i_clr   (hold_clr),
    .i_en    (hold_en),
    .o_count (hold_cnt),
    .o_tc    (hold_tc)
  );

  run_counter #(
    .WIDTH    (CNT_W),
    .TERMINAL (TIMEOUT)
  ) u_cyc_cnt (
    .clk     (Clk),
    .rst_n   (Reset),
    .i_clr   (cyc_clr),
    .i_en    (cyc_en),
    .o_count (cyc_cnt),
    .o_tc    (cyc_tc)
  );

  // Next-state and counter control. Dropping Req is checked first in HOLD
  // and RUN so that an abort outranks both the hold expiry and CoreDone.
  // CoreDone is only looked at in RUN; anything it does elsewhere is ignored.
  always_comb begin
    state_d     = state_q;
    timed_out_d = timed_out_q;
    hold_clr    = 1'b0;
    hold_en     = 1'b0;
    cyc_clr     = 1'b0;
    cyc_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (Req) begin
          state_d     = HOLD;
          hold_clr    = 1'b1;
          cyc_clr     = 1'b1;
          timed_out_d = 1'b0;
        end
      end

      HOLD: begin
        if (!Req) begin
          state_d = IDLE;
        end else begin
          hold_en = 1'b1;
          if (hold_tc) begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        if (!Req) begin
          state_d = IDLE;
        end else begin
          // The cycle that samples Done (or hits the limit) is counted too.
          cyc_en = 1'b1;
          if (CoreDone) begin
            state_d     = REPORT;
            timed_out_d = 1'b0;
          end else if (cyc_tc) begin
            state_d     = REPORT;
            timed_out_d = 1'b1;
          end
        end
      end

      REPORT: begin
        // Req held high here must not start another run; only a drop exits.
        if (!Req) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state and registered alongside it,
    // so they change on the same edge as the state and never follow inputs
    // combinationally.
    core_reset_d = (state_d == IDLE) || (state_d == HOLD);
    busy_d       = (state_d == HOLD) || (state_d == RUN);
    ack_d        = (state_d == REPORT);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= IDLE;
      core_reset_q <= 1'b1;
      ack_q        <= 1'b0;
      busy_q       <= 1'b0;
      timed_out_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      core_reset_q <= core_reset_d;
      ack_q        <= ack_d;
      busy_q       <= busy_d;
      timed_out_q  <= timed_out_d;
    end
  end

  assign Ack        = ack_q;
  assign CoreReset  = core_reset_q;
  assign Busy       = busy_q;
  assign CycleCount = cyc_cnt;
  assign TimedOut   = timed_out_q;

endmodule : core_run_ctrl
`default_nettype wire

// File: tb/tb_core_run_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_core_run_ctrl                                           |
// | Description : Scoreboard bench for core_run_ctrl. The driver plans each  |
// |               run (Done cycle, optional Req drop, Done glitches), asks   |
// |               the reference model for the outcome and queues it; the     |
// |               monitor pops and compares on every Ack rising edge.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_core_run_ctrl;

  localparam int RC = 2;
  localparam int TO = 16;
  localparam int CW = 16;

  logic          Clk      = 1'b0;
  logic          Reset    = 1'b1;
  logic          Req      = 1'b0;
  logic          CoreDone = 1'b0;
  logic          Ack;
  logic          CoreReset;
  logic          Busy;
  logic [CW-1:0] CycleCount;
  logic          TimedOut;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int cnt;
    bit to;
  } exp_t;

  exp_t sb[$];

  core_run_ctrl #(
    .RESET_CYCLES (RC),
    .TIMEOUT      (TO),
    .CNT_W        (CW)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Req        (Req),
    .Ack        (Ack),
    .CoreReset  (CoreReset),
    .CoreDone   (CoreDone),
    .Busy       (Busy),
    .CycleCount (CycleCount),
    .TimedOut   (TimedOut)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req_v, $time);
    end
  endtask

  // Reference model. A run that is not aborted ends at RUN cycle cnt: the
  // Done cycle if Done arrives within TIMEOUT cycles, otherwise TIMEOUT.
  // Negedge n after the accepting edge E0 drives inputs sampled at edge
  // E0+n; the run's last sampling edge is E0+RC+cnt. A Req drop sampled at
  // or before that edge aborts the run (abort beats Done in the same cycle).
  function automatic void model(input int done_k, input int abort_n,
                                output bit aborted, output int cnt, output bit to);
    bit done_in_time;
    done_in_time = (done_k != 0) && (done_k <= TO);
    cnt          = done_in_time ? done_k : TO;
    to           = !done_in_time;
    aborted      = (abort_n != 0) && (abort_n <= RC + cnt);
  endfunction

  // Done is held from its RUN cycle onward; glitch_n adds a one-cycle pulse
  // while the core is still held in reset.
  function automatic logic done_at(input int n, input int done_k, input int glitch_n);
    return ((done_k != 0) && (n >= RC + done_k)) || (n == glitch_n);
  endfunction

  // Monitor: compares each Ack rise against the head of the scoreboard and
  // measures how long CoreReset stayed low before it.
  int low_cnt  = 0;
  bit prev_ack = 1'b0;

  always @(negedge Clk) begin
    exp_t e;
    if (!Reset) begin
      low_cnt  = 0;
      prev_ack = 1'b0;
    end else begin
      if (Ack && !prev_ack) begin
        check("ack_expected", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("ack_count", 32'(CycleCount), e.cnt);
          check("ack_timedout", 32'(TimedOut), 32'(e.to));
          check("corereset_low_cycles", low_cnt, e.cnt);
          check("ack_busy", 32'(Busy), 0);
          check("ack_corereset", 32'(CoreReset), 0);
        end
      end
      if (CoreReset) low_cnt = 0;
      else if (!Ack) low_cnt++;
      prev_ack = Ack;
    end
  end

  task automatic do_run(input int done_k, input int abort_n, input int glitch_n, input int linger);
    bit aborted;
    int cnt;
    bit to;
    bit got;
    int seen_n;
    model(done_k, abort_n, aborted, cnt, to);
    if (!aborted) sb.push_back('{cnt, to});

    @(negedge Clk);
    Req      = 1'b1;
    CoreDone = 1'b0;

    if (aborted) begin
      for (int n = 1; n <= abort_n; n++) begin
        @(negedge Clk);
        CoreDone = done_at(n, done_k, glitch_n);
        if (n == abort_n) Req = 1'b0;
      end
      @(negedge Clk);
      check("abort_corereset", 32'(CoreReset), 1);
      check("abort_busy", 32'(Busy), 0);
      check("abort_ack", 32'(Ack), 0);
      CoreDone = 1'b0;
    end else begin
      got    = 1'b0;
      seen_n = 0;
      for (int n = 1; n <= RC + TO + 6; n++) begin
        @(negedge Clk);
        if (Ack) begin
          got    = 1'b1;
          seen_n = n;
          break;
        end
        CoreDone = done_at(n, done_k, glitch_n);
      end
      check("ack_arrived", 32'(got), 1);
      if (got) begin
        check("ack_latency", seen_n, RC + cnt + 1);
        // Req stays high and Done toggles: no retrigger, results stay put.
        for (int i = 0; i < linger; i++) begin
          CoreDone = i[0];
          @(negedge Clk);
          check("linger_ack", 32'(Ack), 1);
          check("linger_busy", 32'(Busy), 0);
          check("linger_count", 32'(CycleCount), cnt);
        end
      end else begin
        sb.delete();
      end
      CoreDone = 1'b0;
      Req      = 1'b0;
      @(negedge Clk);
      check("ack_drop", 32'(Ack), 0);
      check("idle_corereset", 32'(CoreReset), 1);
    end
  endtask

  task automatic reset_mid_run();
    @(negedge Clk);
    Req = 1'b1;
    repeat (RC + 3) @(negedge Clk);
    #2 Reset = 1'b0;
    #1;
    check("midrst_corereset", 32'(CoreReset), 1);
    check("midrst_ack", 32'(Ack), 0);
    check("midrst_busy", 32'(Busy), 0);
    check("midrst_count", 32'(CycleCount), 0);
    Req = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    check("midrst_after_ack", 32'(Ack), 0);
  endtask

  task automatic idle_glitch();
    @(negedge Clk);
    CoreDone = 1'b1;
    @(negedge Clk);
    CoreDone = 1'b0;
    @(negedge Clk);
    check("idle_glitch_busy", 32'(Busy), 0);
    check("idle_glitch_corereset", 32'(CoreReset), 1);
    check("idle_glitch_ack", 32'(Ack), 0);
  endtask

  initial begin
    #2 Reset = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_corereset", 32'(CoreReset), 1);
    check("rst_ack", 32'(Ack), 0);
    check("rst_busy", 32'(Busy), 0);
    check("rst_count", 32'(CycleCount), 0);
    check("rst_timedout", 32'(TimedOut), 0);
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    check("idle_corereset", 32'(CoreReset), 1);
    check("idle_ack", 32'(Ack), 0);
    check("idle_busy", 32'(Busy), 0);

    do_run(5, 0, 0, 0);        // Done on the 5th RUN cycle
    do_run(0, 0, 0, 0);        // Done never rises: timeout
    do_run(TO, 0, 0, 0);       // Done on the timeout cycle: Done wins
    do_run(TO + 1, 0, 0, 0);   // Done one cycle too late
    do_run(0, RC + 3, 0, 0);   // Req dropped in RUN cycle 3
    do_run(4, 1, 0, 0);        // Req dropped in HOLD
    do_run(3, RC + 3, 0, 0);   // Done and drop in the same cycle
    reset_mid_run();
    do_run(7, 0, 1, 3);        // Done glitch in HOLD, Req held after Ack
    idle_glitch();
    do_run(1, 0, RC, 2);       // glitch on the HOLD->RUN edge, Done at once

    for (int r = 0; r < 40; r++) begin
      int dk;
      int an;
      dk = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, TO + 4));
      an = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, RC + TO + 2)) : 0;
      do_run(dk, an, int'($urandom_range(0, RC)), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 3) == 0) idle_glitch();
    end

    repeat (3) @(negedge Clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_core_run_ctrl
`default_nettype wire
